// File: rtl/regfile_checker_pkg.sv
// -----------------------------------------------------------------------------
// regfile_checker_pkg
// Shared types and default widths for the regfile self-check unit.
//   state_e       : checker FSM states (IDLE -> RUN -> CHECK -> DONE)
//   DEF_*         : default parameter values used by the top and the shadow
// -----------------------------------------------------------------------------
package regfile_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_CYCLE_W  = 32;
  localparam int DEF_ERR_W    = 16;

endpackage

// File: rtl/regfile_checker_shadow.sv
// -----------------------------------------------------------------------------
// regfile_checker_shadow
// Shadow copy of the processor register file: NUM_REGS x DATA_W flops with
// one write port, one combinational read port and a synchronous clear.
// Register 0 is hard-wired to zero by blocking every write to index 0.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (clears all entries)
//   clr_i           synchronous clear of every entry (wins over a write)
//   we_i            write enable
//   waddr_i/wdata_i write index / data
//   raddr_i         read index
//   rdata_o         read data (combinational)
// -----------------------------------------------------------------------------
module regfile_checker_shadow
  import regfile_checker_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/regfile_checker.sv
// -----------------------------------------------------------------------------
// regfile_checker
// Snoops the regfile write port for cycle_limit cycles into a shadow image,
// then walks the image against an external expected-value ROM and counts
// mismatches (saturating). Results are held in DONE until the next start.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   start             one-cycle pulse, starts or restarts a run from any state
//   cycle_limit       RUN length, sampled on start
//   wr_en/wr_reg/wr_data  snooped regfile write port (used only in RUN)
//   exp_addr          ROM read address; exp_data/exp_check arrive 1 cycle later
//   busy/done/pass    status; pass = done && error_count == 0
//   error_count       saturating mismatch count
//   cycle_count       RUN cycles elapsed
//   dbg_state         current FSM state (state_e encoding)
// Optional build macro REGFILE_CHECKER_FIRST_ERR_EN adds first_err_reg,
// first_err_got and first_err_exp, holding the first mismatch of the run.
//
// Handshake: there is no valid/ready pair; start is a one-cycle pulse and the
// ROM is a fixed-latency (1 cycle) slave qualified per entry by exp_check.
// -----------------------------------------------------------------------------
module regfile_checker
  import regfile_checker_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int CYCLE_W  = DEF_CYCLE_W,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CYCLE_W-1:0] cycle_limit,
  input  logic               wr_en,
  input  logic [REG_AW-1:0]  wr_reg,
  input  logic [DATA_W-1:0]  wr_data,
  output logic [REG_AW-1:0]  exp_addr,
  input  logic [DATA_W-1:0]  exp_data,
  input  logic               exp_check,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   error_count,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [1:0]         dbg_state
`ifdef REGFILE_CHECKER_FIRST_ERR_EN
  ,
  output logic [REG_AW-1:0]  first_err_reg,
  output logic [DATA_W-1:0]  first_err_got,
  output logic [DATA_W-1:0]  first_err_exp
`endif
);

  // CHECK step counter runs 0..NUM_REGS: step c issues address c and compares
  // index c-1, so it needs one bit more than a register index.
  localparam int CNT_W = REG_AW + 1;
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(NUM_REGS);
  localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(NUM_REGS - 1);

  state_e             state_q, state_d;
  logic [CYCLE_W-1:0] limit_q, limit_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   step_q, step_d;

  logic               sh_clr;
  logic               sh_we;
  logic [REG_AW-1:0]  sh_raddr;
  logic [DATA_W-1:0]  sh_rdata;
  logic               mismatch;

`ifdef REGFILE_CHECKER_FIRST_ERR_EN
  logic [REG_AW-1:0]  fe_reg_q, fe_reg_d;
  logic [DATA_W-1:0]  fe_got_q, fe_got_d;
  logic [DATA_W-1:0]  fe_exp_q, fe_exp_d;
`endif

  regfile_checker_shadow #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_shadow (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clr_i   (sh_clr),
    .we_i    (sh_we),
    .waddr_i (wr_reg),
    .wdata_i (wr_data),
    .raddr_i (sh_raddr),
    .rdata_o (sh_rdata)
  );

  // The ROM answers one cycle after the address, so the shadow is read at the
  // index issued in the previous step.
  assign sh_raddr = step_q[REG_AW-1:0] - REG_AW'(1);
  assign mismatch = exp_check && (sh_rdata != exp_data);

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    cycle_d = cycle_q;
    err_d   = err_q;
    step_d  = step_q;
    sh_clr  = 1'b0;
    sh_we   = 1'b0;
`ifdef REGFILE_CHECKER_FIRST_ERR_EN
    fe_reg_d = fe_reg_q;
    fe_got_d = fe_got_q;
    fe_exp_d = fe_exp_q;
`endif
    if (start) begin
      state_d = ST_RUN;
      limit_d = cycle_limit;
      cycle_d = '0;
      err_d   = '0;
      step_d  = '0;
      sh_clr  = 1'b1;
`ifdef REGFILE_CHECKER_FIRST_ERR_EN
      fe_reg_d = '0;
      fe_got_d = '0;
      fe_exp_d = '0;
`endif
    end else begin
      case (state_q)
        ST_RUN: begin
          if (limit_q == '0) begin
            // Zero-length run: one idle RUN cycle, nothing captured.
            state_d = ST_CHECK;
          end else begin
            cycle_d = cycle_q + CYCLE_W'(1);
            sh_we   = wr_en;
            if ((cycle_q + CYCLE_W'(1)) == limit_q) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          step_d = step_q + CNT_W'(1);
          if (step_q != '0 && mismatch) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
`ifdef REGFILE_CHECKER_FIRST_ERR_EN
            if (err_q == '0) begin
              fe_reg_d = sh_raddr;
              fe_got_d = sh_rdata;
              fe_exp_d = exp_data;
            end
`endif
          end
          if (step_q == LAST_STEP) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      cycle_q <= '0;
      err_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      cycle_q <= cycle_d;
      err_q   <= err_d;
      step_q  <= step_d;
    end
  end

`ifdef REGFILE_CHECKER_FIRST_ERR_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fe_reg_q <= '0;
      fe_got_q <= '0;
      fe_exp_q <= '0;
    end else begin
      fe_reg_q <= fe_reg_d;
      fe_got_q <= fe_got_d;
      fe_exp_q <= fe_exp_d;
    end
  end

  assign first_err_reg = fe_reg_q;
  assign first_err_got = fe_got_q;
  assign first_err_exp = fe_exp_q;
`endif

  // Hold the address at the last index during the final compare-only step.
  assign exp_addr    = (step_q == LAST_STEP) ? LAST_IDX : step_q[REG_AW-1:0];
  assign busy        = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done        = (state_q == ST_DONE);
  assign pass        = done && (err_q == '0);
  assign error_count = err_q;
  assign cycle_count = cycle_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_regfile_checker.sv
module tb_regfile_checker;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int CW = 32;
  localparam int EW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] cycle_limit;
  logic          wr_en;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] exp_data;
  logic          exp_check;

  logic [AW-1:0] exp_addr, exp_addr2;
  logic          busy, done, pass, busy2, done2, pass2;
  logic [EW-1:0] error_count;
  logic [1:0]    error_count2;
  logic [CW-1:0] cycle_count, cycle_count2;
  logic [1:0]    dbg_state, dbg_state2;
`ifdef REGFILE_CHECKER_FIRST_ERR_EN
  logic [AW-1:0] first_err_reg, first_err_reg2;
  logic [DW-1:0] first_err_got, first_err_got2, first_err_exp, first_err_exp2;
`endif

  always #5 clock = ~clock;

  regfile_checker dut (
    .clock(clock), .reset(reset), .start(start), .cycle_limit(cycle_limit),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_check(exp_check),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .cycle_count(cycle_count), .dbg_state(dbg_state)
`ifdef REGFILE_CHECKER_FIRST_ERR_EN
    , .first_err_reg(first_err_reg), .first_err_got(first_err_got),
    .first_err_exp(first_err_exp)
`endif
  );

  // Second instance with a 2-bit error counter to observe saturation.
  regfile_checker #(.ERR_W(2)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .cycle_limit(cycle_limit),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .exp_addr(exp_addr2), .exp_data(exp_data), .exp_check(exp_check),
    .busy(busy2), .done(done2), .pass(pass2), .error_count(error_count2),
    .cycle_count(cycle_count2), .dbg_state(dbg_state2)
`ifdef REGFILE_CHECKER_FIRST_ERR_EN
    , .first_err_reg(first_err_reg2), .first_err_got(first_err_got2),
    .first_err_exp(first_err_exp2)
`endif
  );

  // ---------------- expected-value ROM (1-cycle latency) ----------------
  logic [DW-1:0] rom_data [NR];
  logic          rom_chk  [NR];
  logic [AW-1:0] rom_addr_seen = '0;

  always @(negedge clock) begin
    exp_data      = rom_data[rom_addr_seen];
    exp_check     = rom_chk[rom_addr_seen];
    rom_addr_seen = exp_addr;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Write plan: entry j is presented in the j-th cycle after the start pulse;
  // only entries j < L land inside the RUN window.
  logic          plan_en   [64];
  logic [AW-1:0] plan_reg  [64];
  logic [DW-1:0] plan_data [64];
  logic [DW-1:0] m_sh      [NR];

  task automatic clear_plan();
    for (int j = 0; j < 64; j++) begin
      plan_en[j] = 1'b0; plan_reg[j] = '0; plan_data[j] = '0;
    end
  endtask

  task automatic build_model(input int lim, input int dc);
    for (int i = 0; i < NR; i++) m_sh[i] = '0;
    for (int j = 0; j < dc; j++)
      if (plan_en[j] && j < lim && plan_reg[j] != 0) m_sh[plan_reg[j]] = plan_data[j];
  endtask

  task automatic rom_from_model();
    for (int i = 0; i < NR; i++) begin
      rom_data[i] = m_sh[i]; rom_chk[i] = 1'b1;
    end
  endtask

  // ---------------- driver: one full run ----------------
  task automatic do_run(input string name, input int lim, input int dc);
    int k, done_k, exp_err, first, exp_lat;
    exp_err = 0; first = -1;
    for (int i = 0; i < NR; i++)
      if (rom_chk[i] && m_sh[i] != rom_data[i]) begin
        if (first < 0) first = i;
        exp_err++;
      end
    @(negedge clock);
    cycle_limit = lim; start = 1'b1;
    @(negedge clock);
    start = 1'b0; k = 1; done_k = 0;
    check_eq({name, "_busy"}, busy, 1);
    for (int j = 0; j < dc; j++) begin
      wr_en = plan_en[j]; wr_reg = plan_reg[j]; wr_data = plan_data[j];
      @(negedge clock); k++;
      if (done && done_k == 0) done_k = k;
    end
    wr_en = 1'b0;
    while (done_k == 0 && k < 400) begin
      @(negedge clock); k++;
      if (done) done_k = k;
    end
    exp_lat = 2 + ((lim == 0) ? 1 : lim) + NR;
    check_eq({name, "_latency"}, done_k, exp_lat);
    check_eq({name, "_cycles"}, cycle_count, lim);
    check_eq({name, "_err"}, error_count, exp_err);
    check_eq({name, "_pass"}, pass, exp_err == 0);
    check_eq({name, "_err_sat"}, error_count2, (exp_err > 3) ? 3 : exp_err);
    check_eq({name, "_busy_end"}, busy, 0);
`ifdef REGFILE_CHECKER_FIRST_ERR_EN
    if (first >= 0) begin
      check_eq({name, "_fe_reg"}, first_err_reg, first);
      check_eq({name, "_fe_got"}, first_err_got, m_sh[first]);
      check_eq({name, "_fe_exp"}, first_err_exp, rom_data[first]);
    end
`endif
    repeat (3) @(negedge clock);
    check_eq({name, "_done_hold"}, done, 1);
    check_eq({name, "_err_hold"}, error_count, exp_err);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lim, dc;
    reset = 1'b0; start = 1'b0; cycle_limit = '0;
    wr_en = 1'b0; wr_reg = '0; wr_data = '0;
    clear_plan();
    for (int i = 0; i < NR; i++) begin rom_data[i] = '0; rom_chk[i] = 1'b0; end
    repeat (3) @(negedge clock);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_err", error_count, 0);
    check_eq("rst_cycles", cycle_count, 0);
    check_eq("rst_addr", exp_addr, 0);
    reset = 1'b1;
    @(negedge clock);

    // Basic run: r1, r2 written, r0 write ignored.
    clear_plan();
    plan_en[0] = 1; plan_reg[0] = 1; plan_data[0] = 32'd5;
    plan_en[1] = 1; plan_reg[1] = 2; plan_data[1] = 32'hFFFF_FFFF;
    plan_en[2] = 1; plan_reg[2] = 0; plan_data[2] = 32'd7;
    build_model(10, 3);
    rom_from_model();
    do_run("basic", 10, 3);

    // Same run, r1 mismatches, r2 wrong but skipped.
    rom_data[1] = 32'd6;
    rom_data[2] = 32'h1234; rom_chk[2] = 1'b0;
    do_run("one_err", 10, 3);

    // Final-cycle capture and post-RUN write ignored.
    clear_plan();
    plan_en[9]  = 1; plan_reg[9]  = 3; plan_data[9]  = 32'd9;
    plan_en[10] = 1; plan_reg[10] = 4; plan_data[10] = 32'd1;
    build_model(10, 11);
    rom_from_model();
    do_run("edge_wr", 10, 11);

    // Restart during CHECK: stale r5 must be cleared.
    for (int i = 0; i < NR; i++) begin rom_data[i] = '0; rom_chk[i] = 1'b1; end
    @(negedge clock);
    cycle_limit = 5; start = 1'b1;
    @(negedge clock);
    start = 1'b0; wr_en = 1'b1; wr_reg = 5; wr_data = 32'hAA;
    @(negedge clock);
    wr_en = 1'b0;
    repeat (15) @(negedge clock);
    check_eq("pre_restart_err", error_count, 1);
    check_eq("pre_restart_busy", busy, 1);
    clear_plan();
    plan_en[1] = 1; plan_reg[1] = 6; plan_data[1] = 32'h77;
    build_model(4, 3);
    rom_from_model();
    do_run("restart", 4, 3);

    // Saturation: six mismatches.
    clear_plan();
    build_model(3, 0);
    rom_from_model();
    for (int i = 10; i < 16; i++) rom_data[i] = i + 1;
    do_run("sat", 3, 0);

    // Zero-length run: no captures, all-zero ROM passes.
    clear_plan();
    plan_en[0] = 1; plan_reg[0] = 7; plan_data[0] = 32'h55;
    build_model(0, 1);
    rom_from_model();
    do_run("zero_len", 0, 1);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      lim = $urandom_range(1, 20);
      dc = lim + 2;
      clear_plan();
      for (int j = 0; j < dc; j++) begin
        plan_en[j]   = $urandom_range(0, 1);
        plan_reg[j]  = AW'($urandom_range(0, NR - 1));
        plan_data[j] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom;
      end
      build_model(lim, dc);
      for (int i = 0; i < NR; i++) begin
        rom_data[i] = m_sh[i];
        rom_chk[i]  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) rom_data[i] = m_sh[i] ^ (32'd1 << $urandom_range(0, 31));
      end
      do_run($sformatf("rand%0d", r), lim, dc);
    end

    // Reset mid-RUN.
    @(negedge clock);
    cycle_limit = 100; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (39) @(negedge clock);
    check_eq("mid_cycles", cycle_count, 39);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_cycles", cycle_count, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("post_rst_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_checker.md
# regfile_checker

Synthesizable self-check unit that sits beside the processor/regfile in the skeleton and snoops the regfile write port. For a configured number of cycles it builds a shadow register image. It then walks that image against an expected-value ROM, counts mismatches and reports pass/fail, so register-level checks run on hardware without a simulator. It generalises the cycle-limited, per-register check flow to parametrised data width, register count and counter widths, and adds skip masks and saturating error counts.

## Interface
Parameters:
- DATA_W, 32, regfile data width
- NUM_REGS, 32, registers shadowed and checked (power of two, ≥2)
- REG_AW, $clog2(NUM_REGS), register index width
- CYCLE_W, 32, cycle counter / limit width
- ERR_W, 16, error counter width (saturating)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while 0
- start  in  1  single-cycle pulse; begins (or restarts) a run
- cycle_limit  in  CYCLE_W  RUN length in cycles, sampled on start
- wr_en  in  1  regfile write enable (ctrl_writeEnable)
- wr_reg  in  REG_AW  regfile write index (ctrl_writeReg)
- wr_data  in  DATA_W  regfile write data (data_writeReg)
- exp_addr  out  REG_AW  expected-ROM read address
- exp_data  in  DATA_W  expected value, valid 1 cycle after exp_addr
- exp_check  in  1  qualifies exp_data; 0 = register skipped
- busy  out  1  high in RUN or CHECK
- done  out  1  high in DONE
- pass  out  1  done && error_count==0
- error_count  out  ERR_W  mismatches found
- cycle_count  out  CYCLE_W  RUN cycles elapsed

## Operation
- FSM: IDLE → RUN → CHECK → DONE. start in any state → RUN.
- On start: shadow image cleared to 0, cycle_count=0, error_count=0, limit latched.
- RUN: each cycle cycle_count+1. A cycle with wr_en=1 and wr_reg≠0 writes wr_data to the shadow image. Writes to r0 are ignored; shadow r0 stays 0. Leave RUN when cycle_count reaches the limit. A limit of 0 goes straight to CHECK after one cycle with no captures.
- CHECK: exp_addr steps 0..NUM_REGS-1, one per cycle. The compare for index i happens one cycle later. If exp_check=1 and shadow[i]≠exp_data, then error_count+1, saturating at 2^ERR_W-1. After the last compare → DONE.
- DONE: outputs held until start or reset. wr_en is ignored outside RUN.
- start during RUN/CHECK aborts the current run and restarts cleanly. No partial results are kept.
- Reset values: state IDLE, busy=0, done=0, pass=0, error_count=0, cycle_count=0, exp_addr=0, shadow all 0.

## Timing
- start sampled at edge T; RUN active from T+1; busy=1 from T+1.
- RUN lasts exactly L=cycle_limit cycles. A write presented in the final RUN cycle is captured. Final cycle_count = L.
- CHECK lasts NUM_REGS+1 cycles (1-cycle ROM latency pipeline). done rises on the edge after the last compare.
- Total start→done = 1 + L + NUM_REGS + 1 cycles (L≥1).
- Reset mid-run: immediate return to IDLE. No done pulse.

## Configuration
- REGFILE_CHECKER_FIRST_ERR_EN defined: adds outputs first_err_reg (REG_AW), first_err_got (DATA_W) and first_err_exp (DATA_W). They capture the first mismatch of the run, are cleared on start/reset, and are valid when error_count≠0.
- Undefined: those ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package regfile_checker_pkg: state enum (IDLE/RUN/CHECK/DONE) and default width constants.
- One sub-module, regfile_checker_shadow: NUM_REGS×DATA_W register array with one write port, one read port, synchronous clear and r0 write-blocking.

## Test plan
- Reset mid-RUN (L=100, reset low at cycle 40) → busy=0, done=0, cycle_count=0 immediately.
- L=10; write r1=5, r2=0xFFFFFFFF, r0=7; ROM checks r0=0, r1=5, r2=0xFFFFFFFF → done after 1+10+33 cycles, error_count=0, pass=1.
- Same run, ROM r1=6 and exp_check=0 for r2 with wrong value → error_count=1, pass=0; first_err_reg=1, got=5, exp=6 with the macro defined.
- Write r3=9 in the final RUN cycle and r4=1 one cycle after RUN ends → r3 captured (match on 9); r4 still 0.
- start issued during CHECK → restart, counters and shadow cleared, new run completes normally.
- ERR_W=2, ROM mismatches on 6 registers → error_count saturates at 3. L=0 → CHECK starts after 1 cycle and all-zero ROM passes.
